// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter that shares the async FIFO write port (wclk domain)
// Ports:
//   wclk, w_rst_n : write clock, asynchronous active-low reset
//   req_valid_i   : per-requester data valid
//   req_data_i    : flattened requester data, requester i at [i*DATA_SIZE +: DATA_SIZE]
//   req_ready_o   : per-requester accept (beat moves on valid & ready)
//   full_i        : registered FIFO full flag from the write pointer
//   w_en_o        : FIFO write enable, never high while full_i is high
//   w_data_o      : FIFO write data, muxed by the registered grant
//   gnt_id_o      : index of the current or last grantee
//   busy_o        : high while a burst grant is active
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 8,
    parameter int MAX_BURST = 4,
    localparam int IW = $clog2(NUM_REQ),
    localparam int CW = $clog2(MAX_BURST + 1)
) (
    input  logic                         wclk,
    input  logic                         w_rst_n,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic                         full_i,
    output logic                         w_en_o,
    output logic [DATA_SIZE-1:0]         w_data_o,
    output logic [IW-1:0]                gnt_id_o,
    output logic                         busy_o
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t          state_q;
    logic [IW-1:0]   gnt_id_q, rr_ptr_q, sel_d, rr_ptr_d, idx;
    logic [CW-1:0]   beat_cnt_q;
    logic            valid_g, exit_burst;
    // Walk downward so the candidate closest to rr_ptr_q is assigned last and wins.
    always_comb begin
        sel_d = rr_ptr_q;
        idx   = rr_ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
            sel_d = req_valid_i[idx] ? idx : sel_d;
        end
    end
    assign rr_ptr_d    = (gnt_id_q == IW'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
    assign valid_g     = req_valid_i[gnt_id_q];
    assign busy_o      = state_q == BURST;
    assign gnt_id_o    = gnt_id_q;
    // full_i gates both ready and write so a requester never sees an accept the FIFO drops.
    assign w_en_o      = busy_o & valid_g & ~full_i;
    assign req_ready_o = (busy_o & ~full_i) ? NUM_REQ'(1) << gnt_id_q : '0;
    assign w_data_o    = req_data_i[gnt_id_q*DATA_SIZE +: DATA_SIZE];
    // A full stall with valid held keeps the grant; dropping valid ends it.
    assign exit_burst  = ~valid_g | (w_en_o & (beat_cnt_q == CW'(MAX_BURST - 1)));
    always_ff @(posedge wclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q    <= IDLE;
            gnt_id_q   <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (|req_valid_i) begin
                gnt_id_q   <= sel_d;
                beat_cnt_q <= '0;
                state_q    <= BURST;
            end
        end else begin
            if (w_en_o) beat_cnt_q <= beat_cnt_q + 1'b1;
            if (exit_burst) begin
                state_q  <= IDLE;
                rr_ptr_q <= rr_ptr_d;
            end
        end
    end
endmodule
